// File: rtl/conv_pkg.sv
// Shared geometry, array types and FSM encoding for the conv tile sequencer.
// Engine-facing ports use tile_t / kern_t / res_t so sizes stay in one place.
package conv_pkg;
  localparam int TILE_DIM = 6;
  localparam int K_DIM    = 3;
  localparam int OUT_DIM  = 4;
  localparam int KBYTES   = K_DIM * K_DIM;
  localparam int TBYTES   = TILE_DIM * TILE_DIM;
  localparam int NRES     = OUT_DIM * OUT_DIM;

  typedef enum logic [2:0] {
    LOAD_K,
    LOAD_T,
    CLEAR,
    START,
    WAIT,
    DRAIN
  } state_t;

  typedef logic [7:0] pix_t;
  typedef logic [15:0] word_t;
  typedef pix_t [0:TILE_DIM-1][0:TILE_DIM-1] tile_t;
  typedef pix_t [0:K_DIM-1][0:K_DIM-1] kern_t;
  typedef word_t [0:OUT_DIM-1][0:OUT_DIM-1] res_t;
endpackage

// File: rtl/conv_result_serializer.sv
// Result buffer: captures 16 engine words, streams them row-major.
// Ports: clk/rst, load+c_in capture, active gates out_*, done on last accept.
module conv_result_serializer
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  res_t        c_in,
  input  logic        active,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        done
);

  res_t       res_q;
  logic [3:0] idx;
  word_t      word;
  logic       accept;

  assign word      = res_q[idx[3:2]][idx[1:0]];
  assign accept    = active && out_ready;
  assign out_valid = active;
  assign out_data  = active ? word : '0;
  assign out_last  = active && (idx == 4'(NRES-1));
  assign done      = accept && out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      idx   <= '0;
    end else if (load) begin
      res_q <= c_in;
      idx   <= '0;
    end else if (accept) begin
      idx   <= idx + 4'd1;
    end
  end

endmodule

// File: rtl/conv_tile_sequencer.sv
// Loads kernel+tile bytes, runs the conv engine, streams 16 results.
// Ports: in_* byte load, engine tile/kernel/rst_n/start/done/c, out_* result, err.
module conv_tile_sequencer
  import conv_pkg::*;
#(
  parameter int WAIT_LIMIT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output tile_t       tile_out,
  output kern_t       kernel_out,
  output logic        conv_rst_n,
  output logic        conv_start,
  input  logic        conv_done,
  input  res_t        conv_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        err
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);

  state_t         state, state_nx;
  logic [1:0]     kr, kc;
  logic [2:0]     tr, tc;
  logic [WW-1:0]  wcnt;
  logic           in_fire;
  logic           k_last, t_last;
  logic           capture, timeout;
  logic           drain_done;

  assign in_ready   = (state == LOAD_K) || (state == LOAD_T);
  assign in_fire    = in_valid && in_ready;
  assign k_last     = (kr == 2'(K_DIM-1)) && (kc == 2'(K_DIM-1));
  assign t_last     = (tr == 3'(TILE_DIM-1)) && (tc == 3'(TILE_DIM-1));
  assign capture    = (state == WAIT) && conv_done;
  // wcnt holds the number of WAIT cycles already spent without done
  assign timeout    = (state == WAIT) && !conv_done
                   && (wcnt == WW'(WAIT_LIMIT-1));
  assign conv_start = (state == START);
  // rst clears the engine in the same cycle, not one edge later
  assign conv_rst_n = !(rst || (state == CLEAR));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_K;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_K: if (in_fire && k_last) state_nx = LOAD_T;
      LOAD_T: if (in_fire && t_last) state_nx = CLEAR;
      CLEAR:  state_nx = START;
      START:  state_nx = WAIT;
      WAIT: begin
        if (conv_done)    state_nx = DRAIN;
        else if (timeout) state_nx = LOAD_K;
      end
      DRAIN:  if (drain_done) state_nx = LOAD_K;
      default: state_nx = LOAD_K;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kr         <= '0;
      kc         <= '0;
      tr         <= '0;
      tc         <= '0;
      wcnt       <= '0;
      err        <= 1'b0;
      tile_out   <= '0;
      kernel_out <= '0;
    end else begin
      if ((state == LOAD_K) && in_fire) begin
        kernel_out[kr][kc] <= in_data;
        if (kc == 2'(K_DIM-1)) begin
          kc <= '0;
          kr <= k_last ? 2'd0 : kr + 2'd1;
        end else begin
          kc <= kc + 2'd1;
        end
      end
      if ((state == LOAD_T) && in_fire) begin
        tile_out[tr][tc] <= in_data;
        if (tc == 3'(TILE_DIM-1)) begin
          tc <= '0;
          tr <= t_last ? 3'd0 : tr + 3'd1;
        end else begin
          tc <= tc + 3'd1;
        end
      end
      if (state == WAIT) wcnt <= wcnt + 1'b1;
      else               wcnt <= '0;
      if (timeout) err <= 1'b1;
    end
  end

  conv_result_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .c_in      (conv_c),
    .active    (state == DRAIN),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (drain_done)
  );

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer with a behavioural engine model.
// Ports driven: load stream, engine done/results, result stream ready, rst.
module tb_conv_tile_sequencer;
  import conv_pkg::*;

  localparam int WL = 63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  tile_t       tile_out;
  kern_t       kernel_out;
  logic        conv_rst_n;
  logic        conv_start;
  logic        conv_done;
  res_t        conv_c;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        err;

  always #5 clk = ~clk;

  conv_tile_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tile_out   (tile_out),
    .kernel_out (kernel_out),
    .conv_rst_n (conv_rst_n),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .conv_c     (conv_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // engine model: computes a valid 4x4 convolution a few cycles after start
  logic hang     = 1'b0;
  logic eng_done = 1'b0;
  logic eng_busy = 1'b0;
  int   eng_cnt  = 0;
  res_t eng_c    = '0;

  function automatic res_t conv_model(input tile_t t, input kern_t k);
    res_t r;
    for (int i = 0; i < OUT_DIM; i++)
      for (int j = 0; j < OUT_DIM; j++) begin
        logic [31:0] s;
        s = 0;
        for (int a = 0; a < K_DIM; a++)
          for (int b = 0; b < K_DIM; b++)
            s = s + 32'(k[a][b]) * 32'(t[i+a][j+b]);
        r[i][j] = s[15:0];
      end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!conv_rst_n) begin
      eng_done <= 1'b0;
      eng_busy <= 1'b0;
    end else if (conv_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 4;
    end else if (eng_busy && !hang) begin
      if (eng_cnt == 0) begin
        eng_c    <= conv_model(tile_out, kernel_out);
        eng_done <= 1'b1;
        eng_busy <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign conv_done = eng_done;
  assign conv_c    = eng_c;

  logic [7:0]  kb [9];
  logic [7:0]  tv [36];
  logic [15:0] exp_w [16];
  logic [15:0] got_w [$];
  logic        got_l [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int mode);
    for (int n = 0; n < 9; n++)
      case (mode)
        1:       kb[n] = (n == 4) ? 8'd1 : 8'd0;
        2:       kb[n] = 8'd255;
        default: kb[n] = 8'd1;
      endcase
    for (int n = 0; n < 36; n++)
      case (mode)
        1:       tv[n] = 8'(n);
        2:       tv[n] = 8'd255;
        default: tv[n] = 8'd1;
      endcase
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        case (mode)
          1:       exp_w[i*4+j] = 16'(6*(i+1) + (j+1));
          2:       exp_w[i*4+j] = 16'd60937;
          default: exp_w[i*4+j] = 16'd9;
        endcase
  endtask

  task automatic send_job(input bit rnd);
    logic ok;
    int   g;
    for (int n = 0; n < 45; n++) begin
      if (rnd)
        while ($urandom_range(0, 1) == 0) begin
          in_valid = 1'b0;
          step();
        end
      in_valid = 1'b1;
      in_data  = (n < 9) ? kb[n] : tv[n-9];
      g = 0;
      do begin
        ok = in_ready;
        step();
        g++;
      end while (!ok && g < 300);
      if (!ok) chk("in_ready_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int nmax, input bit slow);
    int          cyc;
    logic        ov, ol, rdy, stalled;
    logic [15:0] od, prev_d;
    cyc = 0;
    stalled = 1'b0;
    prev_d = '0;
    got_w.delete();
    got_l.delete();
    while (got_w.size() < nmax && cyc < 2000) begin
      rdy = slow ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      ov = out_valid;
      od = out_data;
      ol = out_last;
      if (stalled) chk("stall_hold", od, prev_d);
      stalled = ov && !rdy;
      prev_d = od;
      step();
      cyc++;
      if (ov && rdy) begin
        got_w.push_back(od);
        got_l.push_back(ol);
        if (ol) break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic check_results(input string tag);
    chk($sformatf("%s_count", tag), got_w.size(), 16);
    for (int i = 0; i < got_w.size() && i < 16; i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
      chk($sformatf("%s_last%0d", tag, i), got_l[i], (i == 15));
    end
  endtask

  task automatic idle_check(input string tag);
    logic any;
    any = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      if (out_valid) any = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk(tag, any, 0);
  endtask

  task automatic run_job(input int mode, input bit rnd, input bit slow,
                         input string tag);
    set_job(mode);
    send_job(rnd);
    collect(16, slow);
    check_results(tag);
    idle_check({tag, "_extra"});
  endtask

  initial begin
    logic any_ov;
    int   g, nclr;

    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_start", conv_start, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_conv_rst_n", conv_rst_n, 0);
    chk("rst_tile", |tile_out, 0);
    chk("rst_kernel", |kernel_out, 0);
    rst = 1'b0;
    step();

    run_job(0, 1'b0, 1'b0, "ones");
    chk("ones_err", err, 0);
    run_job(1, 1'b0, 1'b0, "center");
    chk("center_first", got_w[0], 7);
    chk("center_final", got_w[15], 28);
    run_job(2, 1'b0, 1'b0, "max");
    run_job(0, 1'b1, 1'b1, "stall");

    // watchdog: engine never reports done
    hang = 1'b1;
    set_job(0);
    send_job(1'b0);
    g = 0;
    nclr = 0;
    while (!conv_start && g < 50) begin
      if (!conv_rst_n) nclr++;
      step();
      g++;
    end
    chk("wd_start_seen", conv_start, 1);
    chk("wd_clear_cycles", nclr, 1);
    any_ov = 1'b0;
    for (int k = 1; k <= WL + 1; k++) begin
      step();
      if (out_valid) any_ov = 1'b1;
      if (k == WL) chk("wd_err_early", err, 0);
      if (k == WL + 1) begin
        chk("wd_err_set", err, 1);
        chk("wd_back_load", in_ready, 1);
      end
    end
    chk("wd_no_output", any_ov, 0);
    hang = 1'b0;
    run_job(1, 1'b0, 1'b0, "after_wd");
    chk("wd_err_sticky", err, 1);

    // reset while the 8th word is on the output
    set_job(0);
    send_job(1'b0);
    collect(7, 1'b0);
    chk("mid_count", got_w.size(), 7);
    chk("mid_w8_valid", out_valid, 1);
    chk("mid_w8_data", out_data, 9);
    rst = 1'b1;
    #1;
    chk("mid_conv_rst_n", conv_rst_n, 0);
    step();
    rst = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_err_clr", err, 0);
    idle_check("mid_no_words");
    run_job(1, 1'b1, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_tile_sequencer.md
CONV_TILE_SEQUENCER -- requirements
Module: conv_tile_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 63: the maximum number of cycles in WAIT before an error is flagged.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid / in_ready / in_data  in / out / in  1 / 1 / 8  load byte stream: 9 kernel bytes then 36 tile bytes, row-major.
REQ-006 tile_out  out  8 x [0:5][0:5]  assembled input tile driven to the engine.
REQ-007 kernel_out  out  8 x [0:2][0:2]  assembled kernel driven to the engine.
REQ-008 conv_rst_n  out  1  engine clear, active low.
REQ-009 conv_start  out  1  engine start pulse.
REQ-010 conv_done  in  1  engine done, sticky until the engine is cleared.
REQ-011 conv_c  in  16 x [0:3][0:3]  engine results.
REQ-012 out_valid / out_ready / out_data / out_last  out / in / out / out  1 / 1 / 16 / 1  result stream.
REQ-013 err  out  1  sticky watchdog error.

Function
REQ-014 SHALL implement the FSM states LOAD_K, LOAD_T, CLEAR, START, WAIT and DRAIN.
REQ-015 A byte transfers only when in_valid and in_ready are both high in the same cycle.
REQ-016 in_ready SHALL be 1 only in LOAD_K and LOAD_T.
REQ-017 LOAD_K: byte k (0..8) SHALL be written to kernel_out[k/3][k%3]; after the 9th byte the FSM SHALL go to LOAD_T.
REQ-018 LOAD_T: byte t (0..35) SHALL be written to tile_out[t/6][t%6]; after the 36th byte the FSM SHALL go to CLEAR.
REQ-019 CLEAR: conv_rst_n SHALL be 0 for exactly one cycle, then the FSM SHALL go to START.
REQ-020 START: conv_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-021 tile_out and kernel_out SHALL remain stable from the CLEAR state until the FSM leaves WAIT.
REQ-022 WAIT: a cycle counter SHALL count up from 0.
  - On conv_done=1, all 16 conv_c values SHALL be captured into an internal buffer and the FSM SHALL go to DRAIN.
  - If the counter reaches WAIT_LIMIT with conv_done still 0, err SHALL be set, the FSM SHALL go to LOAD_K, and no output SHALL be produced.
REQ-023 DRAIN: the 16 buffered words SHALL be emitted row-major, c[0][0] through c[3][3].
  - Each word advances on out_valid and out_ready both high.
  - out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 out_last SHALL be 1 only with the 16th word; after it is accepted the FSM SHALL go to LOAD_K.
REQ-025 out_valid SHALL be 1 only in DRAIN.
REQ-026 Result words SHALL pass through unmodified; the block performs no arithmetic on them beyond capture.
REQ-027 The first accepted byte after DRAIN completes SHALL be kernel byte 0 of the next job.
REQ-028 err SHALL remain set until rst; jobs SHALL continue to run while err=1.
REQ-029 There SHALL be no input-to-output combinational path other than conv_rst_n's dependence on rst.

Reset
REQ-030 While rst=1:
  - the FSM SHALL enter LOAD_K;
  - the byte counters, the wait counter and err SHALL be cleared;
  - in_ready SHALL be 1;
  - out_valid, out_last and conv_start SHALL be 0;
  - out_data SHALL be 0;
  - conv_rst_n SHALL be 0 (combinational on rst), so the engine is also cleared.
REQ-031 tile_out, kernel_out and the result buffer SHALL be cleared to 0.
REQ-032 Reset mid-job (any state) SHALL abandon the job with no further output words, and the block SHALL resume at kernel byte 0.

Structure
REQ-033 Package conv_pkg SHALL hold the following, and the engine-facing array types SHALL use them:
  - TILE_DIM=6, K_DIM=3, OUT_DIM=4;
  - KBYTES=9, TBYTES=36, NRES=16;
  - the FSM state enum.
REQ-034 One sub-module is natural: conv_result_serializer, containing the 16-entry buffer, read index, and out_* handshake.

Verification
REQ-035 Kernel all 1, tile all 1, out_ready=1 -> 16 words of value 9, out_last on the 16th word, err=0.
REQ-036 Kernel center=1 (others 0), tile[r][c]=6r+c -> out word i*4+j = 6(i+1)+(j+1); first word 7, last word 28.
REQ-037 Kernel all 255, tile all 255 -> every word 60937 (16-bit truncation of 9*65025).
REQ-038 in_valid toggled randomly and out_ready toggled with a 1-on/2-off pattern -> same results as REQ-035; out_data stable while stalled; exactly 16 words.
REQ-039 Engine model holds conv_done=0 -> err=1 exactly WAIT_LIMIT cycles after entering WAIT, out_valid never 1, and the next job loads normally.
REQ-040 rst asserted for 1 cycle during the 8th drained word -> no further words, conv_rst_n=0 that cycle, and the next 45-byte load produces a correct full result set.
